// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// master = sequencer side, slave = datapath side.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [5:0] alu_op;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       retire;
    logic       illegal;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               ext_zero, alu_op, reg_we, reg_dst, wb_sel, retire, illegal, fault, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               ext_zero, alu_op, reg_we, reg_dst, wb_sel, retire, illegal, fault, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared instruction/data memory with a ready handshake and optional wait timeout.
module mc_controller #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEM_RD = 4'd3,
        S_LW_WB  = 4'd4,
        S_MEM_WR = 4'd5,
        S_R_EX   = 4'd6,
        S_R_WB   = 4'd7,
        S_I_EX   = 4'd8,
        S_I_WB   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_SLT  = 6'b101010;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_state;
    logic          timeout_hit;

    logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, ext_zero_c;
    logic       reg_we_c, retire_c, illegal_c, fault_c;
    logic [1:0] pc_src_c, alu_src_a_c, alu_src_b_c, reg_dst_c, wb_sel_c;
    logic [5:0] alu_op_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // The counter only advances on a genuine wait cycle; any completion, abort or
    // state change leaves it at zero so each memory state starts counting afresh.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = mem_state && !bus.mem_ready &&
                                 (wait_q == CW'(MEM_TIMEOUT - 1));
            always_comb begin
                wait_d = '0;
                if (mem_state && !bus.mem_ready && !timeout_hit) begin
                    wait_d = wait_q + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
            assign wait_d      = '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_src_c    = 2'd0;
        alu_src_a_c = 2'd0;
        alu_src_b_c = 2'd0;
        ext_zero_c  = 1'b0;
        alu_op_c    = 6'd0;
        reg_we_c    = 1'b0;
        reg_dst_c   = 2'd0;
        wb_sel_c    = 2'd0;
        retire_c    = 1'b0;
        illegal_c   = 1'b0;
        fault_c     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd1;
                alu_op_c    = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively here and held in ALUOut.
                alu_src_b_c = 2'd3;
                alu_op_c    = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_RTYPE:      state_d = (bus.funct == FN_JR) ? S_JR : S_R_EX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_I_EX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        retire_c  = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'd1;
                alu_src_b_c = 2'd2;
                alu_op_c    = ALU_ADD;
                state_d     = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) state_d = S_LW_WB;
            end
            S_LW_WB: begin
                reg_we_c = 1'b1;
                wb_sel_c = 2'd1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_R_EX: begin
                alu_op_c    = bus.funct;
                alu_src_a_c = (bus.funct[5:2] == 4'b0000) ? 2'd2 : 2'd1;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_we_c  = 1'b1;
                reg_dst_c = 2'd1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EX: begin
                alu_src_a_c = 2'd1;
                alu_src_b_c = 2'd2;
                case (bus.op)
                    OP_ANDI: begin alu_op_c = ALU_AND; ext_zero_c = 1'b1; end
                    OP_ORI:  begin alu_op_c = ALU_OR;  ext_zero_c = 1'b1; end
                    OP_XORI: begin alu_op_c = ALU_XOR; ext_zero_c = 1'b1; end
                    OP_SLTI: alu_op_c = ALU_SLT;
                    default: alu_op_c = ALU_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'd1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'd1;
                pc_we_c     = ((bus.op == OP_BEQ) && bus.zero) ||
                              ((bus.op == OP_BNE) && !bus.zero);
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_we_c  = 1'b1;
                pc_src_c = 2'd2;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, which is exactly the link value for $31.
                pc_we_c   = 1'b1;
                pc_src_c  = 2'd2;
                reg_we_c  = 1'b1;
                reg_dst_c = 2'd2;
                wb_sel_c  = 2'd2;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JR: begin
                pc_we_c  = 1'b1;
                pc_src_c = 2'd3;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abort keeps the request and selects stable but suppresses every write.
        if (timeout_hit) begin
            ir_we_c  = 1'b0;
            pc_we_c  = 1'b0;
            mem_we_c = 1'b0;
            fault_c  = 1'b1;
            state_d  = S_FETCH;
        end
    end

    assign bus.mem_req   = rst_n & mem_req_c;
    assign bus.mem_we    = rst_n & mem_we_c;
    assign bus.iord      = rst_n & iord_c;
    assign bus.ir_we     = rst_n & ir_we_c;
    assign bus.pc_we     = rst_n & pc_we_c;
    assign bus.ext_zero  = rst_n & ext_zero_c;
    assign bus.reg_we    = rst_n & reg_we_c;
    assign bus.retire    = rst_n & retire_c;
    assign bus.illegal   = rst_n & illegal_c;
    assign bus.fault     = rst_n & fault_c;
    assign bus.pc_src    = rst_n ? pc_src_c    : 2'd0;
    assign bus.alu_src_a = rst_n ? alu_src_a_c : 2'd0;
    assign bus.alu_src_b = rst_n ? alu_src_b_c : 2'd0;
    assign bus.reg_dst   = rst_n ? reg_dst_c   : 2'd0;
    assign bus.wb_sel    = rst_n ? wb_sel_c    : 2'd0;
    assign bus.alu_op    = rst_n ? alu_op_c    : 6'd0;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction model predicts a summary of the
// control activity; a monitor accumulates the real activity and compares at each retire/fault.
module tb_mc_controller;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_controller_if ctl_if();

    mc_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ctl_if.master)
    );

    typedef struct {
        int op, funct, d0, d1;
        int kind, cycles, n_ir, n_pc, n_reg, n_memwe, n_memreq, n_iord;
        int pc_src, reg_dst, wb_sel, fetch_ok, dec, ex;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0, fails = 0;
    int   issued = 0, done_cnt = 0;
    bit   mon_en = 0, resp_restart = 0, abort_run = 0;
    int   d0_s = 0, d1_s = 0;

    function automatic int pack(int ez, int a, int b, int op);
        return (ez << 10) | (a << 8) | (b << 6) | op;
    endfunction

    function automatic rec_t blank();
        rec_t r;
        r.op = 0; r.funct = 0; r.d0 = 0; r.d1 = 0;
        r.kind = -1; r.cycles = 0; r.n_ir = 0; r.n_pc = 0; r.n_reg = 0;
        r.n_memwe = 0; r.n_memreq = 0; r.n_iord = 0;
        r.pc_src = -1; r.reg_dst = -1; r.wb_sel = -1;
        r.fetch_ok = -1; r.dec = -1; r.ex = -1;
        return r;
    endfunction

    // Reference: what one instruction should do, derived from the instruction's class.
    function automatic rec_t model(int op, int funct, int z, int d0, int d1);
        rec_t e = blank();
        e.op = op; e.funct = funct; e.d0 = d0; e.d1 = d1;
        if (d0 >= TO) begin
            e.kind = 2; e.cycles = TO; e.n_memreq = TO;
            return e;
        end
        e.kind = 0; e.cycles = d0 + 2; e.n_memreq = d0 + 1;
        e.n_ir = 1; e.n_pc = 1; e.fetch_ok = 1; e.dec = pack(0, 0, 3, 'h20);
        case (op)
            'h23, 'h2B: begin
                e.ex = pack(0, 1, 2, 'h20);
                e.cycles += 1;
                if (d1 >= TO) begin
                    e.kind = 2; e.cycles += TO; e.n_memreq += TO; e.n_iord = TO;
                    if (op == 'h2B) e.n_memwe = TO - 1;
                end else begin
                    e.cycles += d1 + 1; e.n_memreq += d1 + 1; e.n_iord = d1 + 1;
                    if (op == 'h23) begin
                        e.cycles += 1; e.n_reg = 1; e.reg_dst = 0; e.wb_sel = 1;
                    end else e.n_memwe = d1 + 1;
                end
            end
            'h00: begin
                if (funct == 'h08) begin
                    e.cycles += 1; e.n_pc = 2; e.pc_src = 3; e.ex = 0;
                end else begin
                    e.cycles += 2; e.n_reg = 1; e.reg_dst = 1; e.wb_sel = 0;
                    e.ex = pack(0, (funct < 4) ? 2 : 1, 0, funct);
                end
            end
            'h08, 'h0C, 'h0D, 'h0E, 'h0A: begin
                e.cycles += 2; e.n_reg = 1; e.reg_dst = 0; e.wb_sel = 0;
                case (op)
                    'h08: e.ex = pack(0, 1, 2, 'h20);
                    'h0C: e.ex = pack(1, 1, 2, 'h24);
                    'h0D: e.ex = pack(1, 1, 2, 'h25);
                    'h0E: e.ex = pack(1, 1, 2, 'h26);
                    default: e.ex = pack(0, 1, 2, 'h2A);
                endcase
            end
            'h04, 'h05: begin
                e.cycles += 1; e.ex = pack(0, 1, 0, 'h22);
                if ((op == 'h04 && z == 1) || (op == 'h05 && z == 0)) begin
                    e.n_pc = 2; e.pc_src = 1;
                end
            end
            'h02: begin e.cycles += 1; e.n_pc = 2; e.pc_src = 2; e.ex = 0; end
            'h03: begin
                e.cycles += 1; e.n_pc = 2; e.pc_src = 2; e.ex = 0;
                e.n_reg = 1; e.reg_dst = 2; e.wb_sel = 2;
            end
            default: e.kind = 1;
        endcase
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory responder: completes each request after the programmed number of wait cycles.
    int rcnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ctl_if.mem_ready = 1'b0;
            rcnt = 0;
        end else begin
            if (resp_restart) begin rcnt = 0; resp_restart = 0; end
            if (!ctl_if.mem_req) begin
                ctl_if.mem_ready = 1'($urandom_range(0, 1));
                rcnt = 0;
            end else if (rcnt >= (ctl_if.iord ? d1_s : d0_s)) begin
                ctl_if.mem_ready = 1'b1;
                rcnt = 0;
            end else begin
                ctl_if.mem_ready = 1'b0;
                rcnt++;
            end
        end
    end

    // Monitor: accumulate per-instruction activity, compare at the completing pulse.
    rec_t obs;
    int   since_ir;
    always @(negedge clk) begin
        #1;
        if (rst_n && mon_en) begin
            obs.cycles++;
            if (ctl_if.ir_we) begin
                obs.n_ir++;
                since_ir = 0;
                obs.fetch_ok = int'(ctl_if.pc_src == 2'd0 && !ctl_if.iord && ctl_if.alu_src_a == 2'd0 &&
                                    ctl_if.alu_src_b == 2'd1 && ctl_if.alu_op == 6'h20 &&
                                    ctl_if.mem_req && !ctl_if.mem_we && !ctl_if.reg_we);
            end else if (since_ir < 99) since_ir++;
            if (ctl_if.pc_we) begin
                obs.n_pc++;
                if (!ctl_if.ir_we) obs.pc_src = int'(ctl_if.pc_src);
            end
            if (ctl_if.reg_we) begin
                obs.n_reg++;
                obs.reg_dst = int'(ctl_if.reg_dst);
                obs.wb_sel  = int'(ctl_if.wb_sel);
            end
            if (ctl_if.mem_we)  obs.n_memwe++;
            if (ctl_if.mem_req) obs.n_memreq++;
            if (ctl_if.iord)    obs.n_iord++;
            if (since_ir == 1)
                obs.dec = pack(int'(ctl_if.ext_zero), int'(ctl_if.alu_src_a), int'(ctl_if.alu_src_b), int'(ctl_if.alu_op));
            if (since_ir == 2)
                obs.ex = pack(int'(ctl_if.ext_zero), int'(ctl_if.alu_src_a), int'(ctl_if.alu_src_b), int'(ctl_if.alu_op));
            if (ctl_if.retire || ctl_if.fault || ctl_if.illegal) begin
                rec_t e;
                string t;
                obs.kind = ctl_if.illegal ? (ctl_if.retire ? 1 : 3) :
                           (ctl_if.fault ? (ctl_if.retire ? 4 : 2) : 0);
                if (ctl_if.fault) resp_restart = 1;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_completion: got kind %0d, expected none", obs.kind);
                end else begin
                    e = exp_q.pop_front();
                    t = $sformatf("txn%0d", done_cnt);
                    check({t, ".kind"},     obs.kind,     e.kind);
                    check({t, ".cycles"},   obs.cycles,   e.cycles);
                    check({t, ".ir_we"},    obs.n_ir,     e.n_ir);
                    check({t, ".pc_we"},    obs.n_pc,     e.n_pc);
                    check({t, ".reg_we"},   obs.n_reg,    e.n_reg);
                    check({t, ".mem_we"},   obs.n_memwe,  e.n_memwe);
                    check({t, ".mem_req"},  obs.n_memreq, e.n_memreq);
                    check({t, ".iord"},     obs.n_iord,   e.n_iord);
                    check({t, ".pc_src"},   obs.pc_src,   e.pc_src);
                    check({t, ".reg_dst"},  obs.reg_dst,  e.reg_dst);
                    check({t, ".wb_sel"},   obs.wb_sel,   e.wb_sel);
                    check({t, ".fetch"},    obs.fetch_ok, e.fetch_ok);
                    check({t, ".decode"},   obs.dec,      e.dec);
                    check({t, ".exec"},     obs.ex,       e.ex);
                    $display("[TB] txn %0d op=%06b funct=%06b d0=%0d d1=%0d kind=%0d cycles=%0d",
                             done_cnt, e.op[5:0], e.funct[5:0], e.d0, e.d1, obs.kind, obs.cycles);
                end
                done_cnt++;
                obs = blank();
                since_ir = 99;
            end
        end else begin
            obs = blank();
            since_ir = 99;
        end
    end

    task automatic run_txn(input logic [5:0] o, input logic [5:0] f, input logic z, input int a0, input int a1);
        if (abort_run) return;
        exp_q.push_back(model(int'(o), int'(f), int'(z), a0, a1));
        issued++;
        ctl_if.op = o; ctl_if.funct = f; ctl_if.zero = z;
        d0_s = a0; d1_s = a1;
        for (int k = 0; k < 80 && done_cnt < issued; k++) @(posedge clk);
        if (done_cnt < issued) begin
            tests++; fails++; abort_run = 1;
            $display("FAIL completion_timeout: got %0d completions, expected %0d", done_cnt, issued);
        end
        #1;
    endtask

    function automatic logic [25:0] out_vec();
        return {ctl_if.mem_req, ctl_if.mem_we, ctl_if.iord, ctl_if.ir_we, ctl_if.pc_we,
                ctl_if.pc_src, ctl_if.alu_src_a, ctl_if.alu_src_b, ctl_if.ext_zero, ctl_if.alu_op,
                ctl_if.reg_we, ctl_if.reg_dst, ctl_if.wb_sel, ctl_if.retire, ctl_if.illegal, ctl_if.fault};
    endfunction

    initial begin
        logic [5:0] ops [14];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        ctl_if.op = 6'h0; ctl_if.funct = 6'h0; ctl_if.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", int'(out_vec()), 0);
        check("reset_state", int'(ctl_if.state), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1;

        run_txn(6'b001000, 6'h00, 0, 0, 0);   // addi, zero-wait
        run_txn(6'b100011, 6'h00, 0, 0, 3);   // lw, 3 wait cycles
        run_txn(6'b000100, 6'h00, 1, 0, 0);   // beq taken
        run_txn(6'b000101, 6'h00, 1, 1, 0);   // bne not taken
        run_txn(6'b000000, 6'b000000, 0, 0, 0); // sll
        run_txn(6'b000000, 6'b100010, 0, 2, 0); // sub
        run_txn(6'b000011, 6'h00, 0, 0, 0);   // jal
        run_txn(6'b111111, 6'h00, 0, 0, 0);   // illegal
        run_txn(6'b001000, 6'h00, 0, 5, 0);   // fetch timeout
        run_txn(6'b101011, 6'h00, 0, 0, 2);   // sw
        run_txn(6'b000000, 6'b001000, 0, 0, 0); // jr
        run_txn(6'b100011, 6'h00, 0, 1, 6);   // lw with data timeout
        run_txn(6'b000010, 6'h00, 0, 0, 0);   // j

        for (int n = 0; n < 150 && !abort_run; n++) begin
            logic [5:0] o, f;
            int a0;
            o = ops[$urandom_range(0, 13)];
            f = ($urandom_range(0, 7) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
            a0 = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 2);
            run_txn(o, f, 1'($urandom_range(0, 1)), a0, $urandom_range(0, 5));
        end

        if (!abort_run) begin
            mon_en = 0;
            ctl_if.op = 6'b101011; d0_s = 0; d1_s = 20;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (ctl_if.state == 4'd5) break;
            end
            @(posedge clk); #3;
            check("sw_mem_we_before_reset", int'(ctl_if.mem_we), 1);
            rst_n = 1'b0;
            #1;
            check("mid_reset_state", int'(ctl_if.state), 0);
            check("mid_reset_mem_we", int'(ctl_if.mem_we), 0);
            check("mid_reset_outputs", int'(out_vec()), 0);
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle sequencer for the MIPS core; replaces the single-cycle combinational decoder.
- A registered FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB over 3-5+ cycles.
- Drives datapath muxes, write enables and the ALU function over one shared instruction/data memory with a ready handshake.
- Instruction fields come from the datapath IR, which is stable from the edge after ir_we.

Parameters:
- MEM_TIMEOUT, 0, if nonzero, cycles a memory wait may last before `fault` pulses and the FSM returns to FETCH; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result==0
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (sw)
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_we  out  1  load IR
- pc_we  out  1  load PC
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=rs
- alu_src_a  out  2  0=PC, 1=rs, 2=shamt
- alu_src_b  out  2  0=rt, 1=const 4, 2=ext imm, 3=sext imm<<2
- ext_zero  out  1  zero-extend imm (andi/ori/xori)
- alu_op  out  6  MIPS funct encoding (add=100000, sub=100010, and=100100, or=100101, xor=100110, slt=101010)
- reg_we  out  1  register-file write
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on an undecodable op
- fault  out  1  one-cycle pulse on memory timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: rst_n=0 asynchronously forces state=FETCH and clears the wait counter. While reset is held, all enables, mem_req and the pulse outputs are 0; mux selects and alu_op are 0.
- Output defaults: 0 in every state unless listed below.
- ALUOut and MDR are latched by the datapath every cycle.
- FETCH(0): mem_req=1, iord=0, a=PC, b=4, alu_op=add.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise hold FETCH.
- DECODE(1): a=PC, b=3, add (computes the branch target).
  - Next state by op: 100011/101011 -> MEMADR; 000000 with funct=001000 -> JR; other 000000 -> R_EX; 001000/001100/001101/001110/001010 -> I_EX; 000100/000101 -> BRANCH; 000010 -> JUMP; 000011 -> JAL.
  - Any other op: illegal=1, retire=1, go to FETCH (executes as a nop).
- MEMADR(2): a=rs, b=2, add. Go to MEM_RD if op=100011, else MEM_WR.
- MEM_RD(3): mem_req=1, iord=1. On mem_ready go to LW_WB.
- LW_WB(4): reg_we=1, reg_dst=0, wb_sel=1, retire=1. Go to FETCH.
- MEM_WR(5): mem_req=1, mem_we=1, iord=1. On mem_ready: retire=1, go to FETCH.
- R_EX(6): alu_op=funct; b=0; a=2 if funct[5:2]==0 (sll/srl/sra), else a=1. Go to R_WB.
- R_WB(7): reg_we=1, reg_dst=1, wb_sel=0, retire=1. Go to FETCH.
- I_EX(8): a=1, b=2.
  - alu_op per op: addi=add, andi=and, ori=or, xori=xor, slti=slt.
  - ext_zero=1 for andi/ori/xori.
  - Go to I_WB.
- I_WB(9): reg_we=1, reg_dst=0, wb_sel=0, retire=1. Go to FETCH.
- BRANCH(10): a=1, b=0, alu_op=sub, pc_src=1.
  - pc_we=(op==000100 & zero) | (op==000101 & !zero).
  - retire=1, go to FETCH.
- JUMP(11): pc_we=1, pc_src=2, retire=1. Go to FETCH.
- JAL(12): pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2, retire=1. Go to FETCH.
  - The register file captures the pre-edge PC, which is already PC+4.
- JR(13): pc_we=1, pc_src=3, retire=1. Go to FETCH.
- Memory handshake:
  - mem_req stays high and all mux selects stay stable until mem_ready.
  - A mem_ready in the same cycle as mem_req is a zero-wait completion.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter resets on entry to each memory state and increments each wait cycle.
  - When it reaches MEM_TIMEOUT without mem_ready: fault=1, no enables asserted, next state FETCH (PC unchanged).
- Unused state encodings (14, 15): go to FETCH with all enables 0.

Test Plan:
- Reset release, memory zero-wait, IR=addi (op 001000) -> states 0,1,8,9,0; reg_we only in I_WB; reg_dst=0; retire once; pc_we once.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_req/iord=1 held 4 cycles; LW_WB has wb_sel=1; total 8 cycles.
- beq, zero=1 -> pc_we=1 with pc_src=1 in BRANCH; then bne, zero=1 -> pc_we=0; both retire.
- R-type funct=000000 (sll) -> alu_src_a=2; funct=100010 (sub) -> alu_src_a=1, alu_op=100010, reg_dst=1.
- jal -> a single cycle with pc_we, reg_we, reg_dst=2, wb_sel=2; op=111111 -> illegal pulse in DECODE, back to FETCH.
- MEM_TIMEOUT=4, mem_ready held low in FETCH -> fault on the 4th wait cycle, no ir_we/pc_we; rst_n low mid-MEM_WR -> immediate FETCH, mem_we=0.
